dsp_reset_responder: RTL and testbench

ISA-side responder model of the Sound Blaster DSP reset handshake, the opposite end of the port-scan/reset-sequence initiator. It decodes I/O cycles at one base address and answers the reset protocol: a 1 then a 0 is written to BASE+6, then BASE+E bit7 reports data available, and BASE+A returns 0xAA. It is used as the bring-up target for the scanner and as a bench model on the riser.

---
 rtl/dsp_reset_responder.sv | 262 ++++++++++++++++++++++++++
 tb/tb_dsp_reset_responder.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/dsp_reset_responder.sv
// dsp_reset_responder
// ISA-side responder for the Sound Blaster DSP reset handshake.
//
// Protocol:
//   - Write 1 to BASE+6, then write 0 to BASE+6.
//   - After READY_DELAY cycles, BASE+E bit7 reports data available.
//   - BASE+A then returns 0xAA.
//
// Decoded registers: BASE+6 (reset), BASE+A (read data),
// BASE+C (write-buffer status), BASE+E (read-buffer status).
//
// Optional feature macro: DSP_VERSION_EN
//   When defined, a write of 0xE1 to BASE+C in READY queues the version
//   bytes 0x04, 0x05 for subsequent BASE+A reads.
//
// Strobe protocol: io_write / io_read are level strobes already in the
// sys_clock domain. Each is edge-detected with one register. An access
// happens only on the first cycle a strobe is seen high; holding a strobe
// never repeats the access. On a read edge to a decoded address, data_out
// and data_oe are registered on that edge and then held while io_read stays
// high. data_oe drops on the first clock that sees io_read low.

module dsp_reset_responder #(
  parameter logic [15:0] BASE_ADDR   = 16'h0220,
  parameter int          MIN_HOLD    = 8,
  parameter int          READY_DELAY = 16
) (
  input  logic        sys_clock,
  input  logic        reset,
  input  logic [15:0] address,
  input  logic [15:0] data_in,
  input  logic        io_write,
  input  logic        io_read,
  output logic [15:0] data_out,
  output logic        data_oe,
  output logic        dsp_ready
);

  localparam int HOLD_W = $clog2(MIN_HOLD + 1);
  localparam int DLY_W  = $clog2(READY_DELAY + 1);

  localparam logic [HOLD_W-1:0] HOLD_MIN = HOLD_W'(MIN_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);
  localparam logic [DLY_W-1:0]  DLY_LAST = DLY_W'(READY_DELAY - 1);
  localparam logic [DLY_W-1:0]  DLY_ONE  = DLY_W'(1);

  localparam logic [15:0] ADDR_RESET = BASE_ADDR + 16'h0006;
  localparam logic [15:0] ADDR_READ  = BASE_ADDR + 16'h000A;
  localparam logic [15:0] ADDR_WBUF  = BASE_ADDR + 16'h000C;
  localparam logic [15:0] ADDR_RSTAT = BASE_ADDR + 16'h000E;

  localparam logic [7:0] ACK_BYTE = 8'hAA;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_DELAY = 2'd2,
    ST_READY = 2'd3
  } state_t;

  // FSM and handshake state
  state_t            state_q;
  logic [HOLD_W-1:0] hold_q;
  logic [DLY_W-1:0]  dly_q;
  logic              avail_q;
  logic              dsp_ready_q;
  logic [7:0]        out_byte_q;
  logic [7:0]        last_byte_q;

  // Strobe edge-detect registers
  logic              wr_seen_q;
  logic              rd_seen_q;

  // Registered read port
  logic [15:0]       data_out_q;
  logic              data_oe_q;

`ifdef DSP_VERSION_EN
  // Two-entry version queue; the head is always in ver_q0_q
  logic [7:0]        ver_q0_q;
  logic [7:0]        ver_q1_q;
  logic [1:0]        ver_cnt_q;
  logic              ver_wr;
  logic              q_nonempty_eff;
  logic              pop_q;
`endif

  // Decode and edge outputs
  logic              wr_edge;
  logic              rd_edge;
  logic              hit_6;
  logic              hit_a;
  logic              hit_c;
  logic              hit_e;
  logic              rd_decoded;
  logic              arm_wr;
  logic              clr_wr;
  logic              avail_eff;
  logic              status_bit;
  logic              pop_avail;
  logic [15:0]       rd_val;

  // Only data_in[0] (and [7:0] with the version feature) is meaningful
  logic              unused_data_bits;
  assign unused_data_bits = ^data_in[15:1];

  // Rising-edge detection of the write and read strobes
  always_ff @(posedge sys_clock) begin
    if (reset) begin
      wr_seen_q <= 1'b0;
      rd_seen_q <= 1'b0;
    end else begin
      wr_seen_q <= io_write;
      rd_seen_q <= io_read;
    end
  end

  // Address decode, access classification and read-data mux.
  // A write is applied before a coincident read, so the read path uses the
  // post-write view of avail and of the queue.
  always_comb begin
    wr_edge    = io_write & ~wr_seen_q;
    rd_edge    = io_read  & ~rd_seen_q;
    hit_6      = (address == ADDR_RESET);
    hit_a      = (address == ADDR_READ);
    hit_c      = (address == ADDR_WBUF);
    hit_e      = (address == ADDR_RSTAT);
    rd_decoded = hit_a | hit_c | hit_e;

    arm_wr     = wr_edge & hit_6 &  data_in[0];
    clr_wr     = wr_edge & hit_6 & ~data_in[0];

    avail_eff  = avail_q & ~arm_wr;

`ifdef DSP_VERSION_EN
    ver_wr         = wr_edge & hit_c & (data_in[7:0] == 8'hE1);
    q_nonempty_eff = (ver_cnt_q != 2'd0) & ~arm_wr;
    status_bit     = avail_eff | q_nonempty_eff;
    pop_q          = rd_edge & hit_a & ~avail_eff & q_nonempty_eff;
`else
    status_bit     = avail_eff;
`endif

    pop_avail = rd_edge & hit_a & avail_eff;

    rd_val = 16'h0000;
    if (hit_e) begin
      rd_val = {8'h00, status_bit, 7'h7F};
    end else if (hit_c) begin
      rd_val = 16'h007F;
    end else if (hit_a) begin
      if (avail_eff) begin
        rd_val = {8'h00, out_byte_q};
`ifdef DSP_VERSION_EN
      end else if (q_nonempty_eff) begin
        rd_val = {8'h00, ver_q0_q};
`endif
      end else begin
        rd_val = {8'h00, last_byte_q};
      end
    end
  end

  // Reset-handshake FSM with its counters, avail, pop and status registers
  always_ff @(posedge sys_clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      hold_q      <= '0;
      dly_q       <= '0;
      avail_q     <= 1'b0;
      dsp_ready_q <= 1'b0;
      out_byte_q  <= 8'h00;
      last_byte_q <= 8'h00;
`ifdef DSP_VERSION_EN
      ver_q0_q    <= 8'h00;
      ver_q1_q    <= 8'h00;
      ver_cnt_q   <= 2'd0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
        end
        ST_ARMED: begin
          if (clr_wr) begin
            if (hold_q >= HOLD_MIN) begin
              state_q <= ST_DELAY;
              dly_q   <= '0;
            end else begin
              // Released too early: reset rejected, no ack
              state_q <= ST_IDLE;
            end
          end else if (hold_q < HOLD_MIN) begin
            hold_q <= hold_q + HOLD_ONE;
          end
        end
        ST_DELAY: begin
          if (dly_q == DLY_LAST) begin
            state_q    <= ST_READY;
            avail_q    <= 1'b1;
            out_byte_q <= ACK_BYTE;
          end else begin
            dly_q <= dly_q + DLY_ONE;
          end
        end
        ST_READY: begin
        end
        default: state_q <= ST_IDLE;
      endcase

      if (pop_avail) begin
        avail_q     <= 1'b0;
        last_byte_q <= out_byte_q;
        dsp_ready_q <= 1'b1;
      end

`ifdef DSP_VERSION_EN
      if (pop_q) begin
        ver_q0_q    <= ver_q1_q;
        ver_cnt_q   <= ver_cnt_q - 2'd1;
        last_byte_q <= ver_q0_q;
      end
      if (ver_wr && (state_q == ST_READY) && (ver_cnt_q == 2'd0)) begin
        ver_q0_q  <= 8'h04;
        ver_q1_q  <= 8'h05;
        ver_cnt_q <= 2'd2;
      end
`endif

      // A "1" to the reset port aborts whatever is in progress and re-arms.
      // dsp_ready is sticky.
      if (arm_wr) begin
        state_q <= ST_ARMED;
        hold_q  <= '0;
        dly_q   <= '0;
        avail_q <= 1'b0;
`ifdef DSP_VERSION_EN
        ver_cnt_q <= 2'd0;
`endif
      end
    end
  end

  // Registered read port: capture on a decoded read edge, hold while
  // io_read is high, release once io_read is low
  always_ff @(posedge sys_clock) begin
    if (reset) begin
      data_out_q <= 16'h0000;
      data_oe_q  <= 1'b0;
    end else if (rd_edge && rd_decoded) begin
      data_out_q <= rd_val;
      data_oe_q  <= 1'b1;
    end else if (!io_read) begin
      data_out_q <= 16'h0000;
      data_oe_q  <= 1'b0;
    end
  end

  assign data_out  = data_out_q;
  assign data_oe   = data_oe_q;
  assign dsp_ready = dsp_ready_q;

endmodule

// File: tb/tb_dsp_reset_responder.sv
// Testbench for dsp_reset_responder.
// Inputs are driven on the falling clock edge and outputs are sampled there,
// half a cycle after the DUT's rising edge.

module tb_dsp_reset_responder;

  logic        sys_clock = 1'b0;
  logic        reset     = 1'b1;
  logic [15:0] address   = 16'h0000;
  logic [15:0] data_in   = 16'h0000;
  logic        io_write  = 1'b0;
  logic        io_read   = 1'b0;
  logic [15:0] data_out;
  logic        data_oe;
  logic        dsp_ready;

  int total  = 0;
  int passed = 0;

  logic [15:0] exp_q[$];

  typedef struct {
    logic        is_wr;
    logic [15:0] addr;
    logic [7:0]  wdata;
    int          gap;
    logic [15:0] exp_data;
    logic        exp_oe;
    logic        exp_rdy;
  } vec_t;

  vec_t tbl[$];

  dsp_reset_responder dut (
    .sys_clock (sys_clock),
    .reset     (reset),
    .address   (address),
    .data_in   (data_in),
    .io_write  (io_write),
    .io_read   (io_read),
    .data_out  (data_out),
    .data_oe   (data_oe),
    .dsp_ready (dsp_ready)
  );

  // ---------------- clock / reset ----------------
  always #5 sys_clock = ~sys_clock;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, required finish before it");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge sys_clock);
  endtask

  // One-cycle write strobe; returns on the falling edge just after the
  // rising edge that saw the strobe
  task automatic wr_pulse(input logic [15:0] a, input logic [7:0] d);
    address  = a;
    data_in  = {8'h00, d};
    io_write = 1'b1;
    @(negedge sys_clock);
    io_write = 1'b0;
  endtask

  // One-cycle read strobe; samples the port half a cycle after the edge
  task automatic rd_pulse(input logic [15:0] a, output logic [15:0] d,
                          output logic oe);
    address = a;
    io_read = 1'b1;
    @(negedge sys_clock);
    d       = data_out;
    oe      = data_oe;
    io_read = 1'b0;
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, required %h", name, act, exp);
  endtask

  task automatic check_read(input string name, input logic [15:0] a,
                            input logic [15:0] exp);
    logic [15:0] d;
    logic        oe;
    exp_q.push_back(exp);
    rd_pulse(a, d, oe);
    check({name, "_oe"}, {15'h0, oe}, 16'h0001);
    check({name, "_data"}, d, exp_q.pop_front());
  endtask

  function automatic void add(input logic w, input logic [15:0] a,
                              input logic [7:0] d, input int g,
                              input logic [15:0] e, input logic oe,
                              input logic rdy);
    vec_t v;
    v.is_wr = w; v.addr = a; v.wdata = d; v.gap = g;
    v.exp_data = e; v.exp_oe = oe; v.exp_rdy = rdy;
    tbl.push_back(v);
  endfunction

  // ---------------- stimulus ----------------
  initial begin : main
    logic [15:0] d;
    logic        oe;

    // Directed table: reset state, decode, rejected reset, full handshake
    add(0, 16'h022E, 8'h00,  1, 16'h007F, 1, 0);
    add(0, 16'h022A, 8'h00,  1, 16'h0000, 1, 0);
    add(0, 16'h022C, 8'h00,  1, 16'h007F, 1, 0);
    add(0, 16'h023A, 8'h00,  1, 16'h0000, 0, 0);
    add(1, 16'h0236, 8'h01, 10, 16'h0000, 0, 0);
    add(1, 16'h0226, 8'h00, 20, 16'h0000, 0, 0);
    add(0, 16'h022E, 8'h00,  1, 16'h007F, 1, 0);
    add(1, 16'h0226, 8'h01,  2, 16'h0000, 0, 0);
    add(1, 16'h0226, 8'h00, 20, 16'h0000, 0, 0);
    add(0, 16'h022E, 8'h00, 20, 16'h007F, 1, 0);
    add(0, 16'h022E, 8'h00,  1, 16'h007F, 1, 0);
    add(1, 16'h0226, 8'h00, 20, 16'h0000, 0, 0);
    add(0, 16'h022E, 8'h00,  1, 16'h007F, 1, 0);
    add(1, 16'h0226, 8'h01, 10, 16'h0000, 0, 0);
    add(1, 16'h0226, 8'h00, 20, 16'h0000, 0, 0);
    add(0, 16'h022E, 8'h00,  1, 16'h00FF, 1, 0);
    add(0, 16'h022A, 8'h00,  1, 16'h00AA, 1, 1);
    add(0, 16'h022E, 8'h00,  1, 16'h007F, 1, 1);
    add(0, 16'h022A, 8'h00,  1, 16'h00AA, 1, 1);
    add(0, 16'h023A, 8'h00,  1, 16'h0000, 0, 1);
    add(1, 16'h0226, 8'h00, 20, 16'h0000, 0, 1);
    add(0, 16'h022E, 8'h00,  1, 16'h007F, 1, 1);

    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(1);
    check("reset_data_out", data_out, 16'h0000);
    check("reset_data_oe", {15'h0, data_oe}, 16'h0000);
    check("reset_dsp_ready", {15'h0, dsp_ready}, 16'h0000);

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].is_wr) begin
        wr_pulse(tbl[i].addr, tbl[i].wdata);
      end else begin
        exp_q.push_back(tbl[i].exp_data);
        rd_pulse(tbl[i].addr, d, oe);
        check($sformatf("vec%0d_oe", i), {15'h0, oe}, {15'h0, tbl[i].exp_oe});
        if (tbl[i].exp_oe) check($sformatf("vec%0d_data", i), d, exp_q[0]);
        void'(exp_q.pop_front());
      end
      check($sformatf("vec%0d_ready", i), {15'h0, dsp_ready}, {15'h0, tbl[i].exp_rdy});
      tick(tbl[i].gap);
    end

    // Re-arm during DELAY restarts the delay from the second "0" write.
    // A read edge on cycle k+16 still sees avail low; one on k+18 sees it high.
    wr_pulse(16'h0226, 8'h01); tick(10);
    wr_pulse(16'h0226, 8'h00); tick(5);
    wr_pulse(16'h0226, 8'h01); tick(10);
    wr_pulse(16'h0226, 8'h00); tick(15);
    check_read("restart_k16", 16'h022E, 16'h007F);
    tick(1);
    check_read("restart_k18", 16'h022E, 16'h00FF);
    tick(1);
    check_read("restart_pop", 16'h022A, 16'h00AA);
    tick(1);

    // Fresh handshake: a read edge on cycle k+17 sees avail high
    wr_pulse(16'h0226, 8'h01); tick(10);
    wr_pulse(16'h0226, 8'h00); tick(16);
    check_read("latency_k17", 16'h022E, 16'h00FF);
    tick(1);

    // Held read on BASE+A: one pop, data held for 5 cycles, oe drops after
    address = 16'h022A;
    io_read = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge sys_clock);
      check($sformatf("held_data_c%0d", c), data_out, 16'h00AA);
      check($sformatf("held_oe_c%0d", c), {15'h0, data_oe}, 16'h0001);
    end
    io_read = 1'b0;
    @(negedge sys_clock);
    check("held_oe_drop", {15'h0, data_oe}, 16'h0000);
    tick(1);
    check_read("held_avail_clear", 16'h022E, 16'h007F);
    check("held_ready", {15'h0, dsp_ready}, 16'h0001);
    tick(1);

    // Version command on BASE+C
    wr_pulse(16'h022C, 8'hE1); tick(2);
`ifdef DSP_VERSION_EN
    check_read("ver_stat0", 16'h022E, 16'h00FF); tick(1);
    check_read("ver_byte0", 16'h022A, 16'h0004); tick(1);
    check_read("ver_stat1", 16'h022E, 16'h00FF); tick(1);
    check_read("ver_byte1", 16'h022A, 16'h0005); tick(1);
    check_read("ver_stat2", 16'h022E, 16'h007F); tick(1);
    check_read("ver_last",  16'h022A, 16'h0005); tick(1);
`else
    check_read("nover_stat", 16'h022E, 16'h007F); tick(1);
    check_read("nover_byte", 16'h022A, 16'h00AA); tick(1);
`endif

    // Reset asserted during DELAY while a read is being driven
    wr_pulse(16'h0226, 8'h01); tick(10);
    wr_pulse(16'h0226, 8'h00); tick(3);
    address = 16'h022E;
    io_read = 1'b1;
    @(negedge sys_clock);
    check("pre_reset_oe", {15'h0, data_oe}, 16'h0001);
    check("pre_reset_data", data_out, 16'h007F);
    check("pre_reset_ready", {15'h0, dsp_ready}, 16'h0001);
    reset = 1'b1;
    @(negedge sys_clock);
    check("rst_delay_data", data_out, 16'h0000);
    check("rst_delay_oe", {15'h0, data_oe}, 16'h0000);
    check("rst_delay_ready", {15'h0, dsp_ready}, 16'h0000);
    reset   = 1'b0;
    io_read = 1'b0;
    tick(25);
    check_read("post_rst_stat", 16'h022E, 16'h007F);
    tick(1);
    check_read("post_rst_last", 16'h022A, 16'h0000);
    check("post_rst_ready", {15'h0, dsp_ready}, 16'h0000);
    tick(2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
